issue_ctrl: RTL
===============

# issue_ctrl

Issue controller between the instruction queue and the decoder/dispatch stage of the out-of-order core. It pops instructions from the instruction queue into a one-entry hold register and presents them to the decoder. It releases each one only when its target station (load/store buffer or reservation station) and the reorder buffer both have room, and it allocates wrapping ROB tags. It tracks ROB occupancy through a credit counter and discards all in-flight issue state on a misprediction flush.

## Interface
- PcLength, 31: MSB index of PC buses (width PcLength+1)
- InstrLength, 31: MSB index of instruction buses
- RobDepth, 16: ROB entries; power of two
- TagLength, 3: MSB index of ROB tag; (TagLength+1) = log2(RobDepth)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- is_empty_from_instr_queue  in  1  1 = queue has no instruction
- pc_from_instr_queue  in  PcLength+1  PC of queue head
- instr_from_instr_queue  in  InstrLength+1  instruction at queue head
- pop_to_instr_queue  out  1  dequeue head this cycle (combinational)
- rs_full  in  1  reservation station cannot accept this cycle
- lsb_full  in  1  load/store buffer cannot accept this cycle
- commit_from_rob  in  1  one ROB entry retired this cycle (frees one credit)
- flush  in  1  misprediction flush; downstream ROB/RS/LSB are emptied the same cycle
- issue_valid  out  1  instruction on issue bus is issued this cycle
- pc_to_dc  out  PcLength+1  held PC
- instr_to_dc  out  InstrLength+1  held instruction
- tag_to_dc  out  TagLength+1  ROB tag allocated to held instruction
- to_lsb  out  1  1 = target is LSB, 0 = target is RS
- is_empty_to_dc  out  1  1 = hold register empty

## Operation
- State: hold_valid (EMPTY/FULL), hold pc/instr, tag pointer (TagLength+1 bits), credits (TagLength+2 bits, range 0..RobDepth).
- Target class: instr[6:0] == 7'b0000011 (load) or 7'b0100011 (store) -> to_lsb=1; all other opcodes -> to_lsb=0. Combinational from the hold register.
- can_issue = hold_valid & credits != 0 & !(to_lsb ? lsb_full : rs_full) & !flush.
- issue_valid = can_issue. tag_to_dc = tag pointer. On issue, tag pointer increments and wraps from RobDepth-1 to 0.
- pop_to_instr_queue = !flush & !is_empty_from_instr_queue & (!hold_valid | can_issue). The popped instruction loads the hold register at the next edge.
- EMPTY -> FULL on pop. FULL -> FULL on issue with pop, or on no issue. FULL -> EMPTY on issue without pop.
- Credits: issue only -> -1. Commit only -> +1. Both or neither -> unchanged. Commit at credits==RobDepth is ignored (saturate).
- Flush has priority over everything:
  - no issue, no pop;
  - next cycle: hold_valid=0, tag pointer=0, credits=RobDepth;
  - a commit in the flush cycle is ignored.
- pc_to_dc and instr_to_dc hold their last value while EMPTY, and are zero after reset.

## Timing
- Reset values: is_empty_to_dc=1, issue_valid=0, pop_to_instr_queue=0 (hold_valid=0 and queue gated), pc_to_dc=0, instr_to_dc=0, tag_to_dc=0, to_lsb=0 (instr=0), credits=RobDepth.
- Reset asserted mid-operation clears state immediately (async), discarding the held instruction. The first pop is possible in the first cycle with rst low.
- Latency: popped at edge t -> presented and issuable in cycle t+1. Sustained throughput is 1 instruction per cycle with no stalls.
- Outputs issue_valid, pop_to_instr_queue and to_lsb are combinational from state and this cycle's inputs. Downstream samples them at the next edge.
- A stall holds pc/instr/tag stable until issue. No instruction is ever dropped or duplicated except by flush or reset.

## Test plan
- Back-to-back issue: queue holds 4 ALU instrs (opcode 0110011), PCs 0x0,0x4,0x8,0xC, no stalls -> issue_valid high 4 consecutive cycles, tags 0,1,2,3, to_lsb=0, first issue one cycle after first pop.
- Target routing/stall: held load (0000011) with lsb_full=1, rs_full=0 -> issue_valid=0 and pop=0 until lsb_full drops; then issues with to_lsb=1 and the same tag. An ALU instr under rs_full=1 stalls likewise.
- ROB credits/wrap: RobDepth=16, no commits, 17 instrs -> 16 issue with tags 0..15, 17th stalls. One commit_from_rob pulse -> 17th issues next cycle with tag 0. Commit and issue in the same cycle leaves credits unchanged.
- Flush: FULL with tag pointer=5, credits=10, flush=1 with queue non-empty -> no issue or pop that cycle. Next cycle is_empty_to_dc=1, credits=16; next issued tag is 0.
- Async reset mid-stream: assert rst between clock edges while FULL -> is_empty_to_dc=1, issue_valid=0, pc_to_dc=0 immediately, before the next edge.
- Commit saturation: credits=16, commit_from_rob=1 -> credits stay 16; the next 16 issues proceed, the 17th stalls.

Source files
------------

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
//
// Purpose:
//   Sits between the instruction queue and the decoder/dispatch stage. It pops
//   the queue head into a one-entry hold register, presents it to the decoder
//   and releases it only when the target station (LSB for loads/stores, RS for
//   everything else) and the ROB both have room. Each issued instruction gets
//   the next wrapping ROB tag. ROB occupancy is tracked with a credit counter
//   (one credit per free ROB entry). A misprediction flush drops the held
//   instruction and restores the tag pointer and credits to their idle values.
//
// Ports:
//   clk                        in   clock, rising-edge state updates
//   rst                        in   asynchronous active-high reset
//   is_empty_from_instr_queue  in   1 = queue has no instruction
//   pc_from_instr_queue        in   PC of queue head
//   instr_from_instr_queue     in   instruction at queue head
//   pop_to_instr_queue         out  dequeue head this cycle (combinational)
//   rs_full                    in   reservation station cannot accept
//   lsb_full                   in   load/store buffer cannot accept
//   commit_from_rob            in   one ROB entry retired (frees one credit)
//   flush                      in   misprediction flush
//   issue_valid                out  held instruction issues this cycle
//   pc_to_dc                   out  held PC
//   instr_to_dc                out  held instruction
//   tag_to_dc                  out  ROB tag for the held instruction
//   to_lsb                     out  1 = target is LSB, 0 = target is RS
//   is_empty_to_dc             out  1 = hold register empty
// ---------------------------------------------------------------------------
module issue_ctrl #(
  parameter int PcLength    = 31,
  parameter int InstrLength = 31,
  parameter int RobDepth    = 16,
  parameter int TagLength   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_empty_from_instr_queue,
  input  logic [PcLength:0]    pc_from_instr_queue,
  input  logic [InstrLength:0] instr_from_instr_queue,
  output logic                 pop_to_instr_queue,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic                 commit_from_rob,
  input  logic                 flush,
  output logic                 issue_valid,
  output logic [PcLength:0]    pc_to_dc,
  output logic [InstrLength:0] instr_to_dc,
  output logic [TagLength:0]   tag_to_dc,
  output logic                 to_lsb,
  output logic                 is_empty_to_dc
);

  localparam int TagW  = TagLength + 1;
  localparam int CredW = TagLength + 2;

  localparam logic [CredW-1:0] CRED_MAX = CredW'(RobDepth);
  localparam logic [CredW-1:0] CRED_ONE = CredW'(1);
  localparam logic [TagW-1:0]  TAG_ONE  = TagW'(1);
  localparam logic [TagW-1:0]  TAG_ZERO = '0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  hold_state_t          r_state;
  logic [PcLength:0]    r_pc;
  logic [InstrLength:0] r_instr;
  logic [TagW-1:0]      r_tag;
  logic [CredW-1:0]     r_credits;

  logic w_to_lsb;
  logic w_target_full;
  logic w_can_issue;
  logic w_pop;

  // Credit update: one credit consumed per issue, one returned per commit.
  // A commit arriving while every ROB entry is already free is dropped so the
  // counter never exceeds RobDepth.
  function automatic logic [CredW-1:0] next_credits(
    input logic [CredW-1:0] cur,
    input logic             issue,
    input logic             commit
  );
    logic [CredW-1:0] res;
    res = cur;
    case ({issue, commit})
      2'b10:   res = cur - CRED_ONE;
      2'b01:   res = (cur == CRED_MAX) ? cur : cur + CRED_ONE;
      default: res = cur;
    endcase
    return res;
  endfunction

  // ---- issue decision (combinational from hold register + this cycle) ----
  assign w_to_lsb      = (r_instr[6:0] == OP_LOAD) || (r_instr[6:0] == OP_STORE);
  assign w_target_full = w_to_lsb ? lsb_full : rs_full;
  assign w_can_issue   = (r_state == FULL) && (r_credits != '0) &&
                         !w_target_full && !flush;
  // The hold register can take a new instruction when it is empty or when
  // its current occupant leaves this same cycle.
  assign w_pop         = !flush && !is_empty_from_instr_queue &&
                         ((r_state == EMPTY) || w_can_issue);

  assign issue_valid        = w_can_issue;
  assign pop_to_instr_queue = w_pop;
  assign to_lsb             = w_to_lsb;
  assign pc_to_dc           = r_pc;
  assign instr_to_dc        = r_instr;
  assign tag_to_dc          = r_tag;
  assign is_empty_to_dc     = (r_state == EMPTY);

  // ---- hold register / tag pointer / credits (state at rising edge) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_pc      <= '0;
      r_instr   <= '0;
      r_tag     <= TAG_ZERO;
      r_credits <= CRED_MAX;
    end else if (flush) begin
      // Downstream structures are emptied in the same cycle, so every ROB
      // entry is free again; pc/instr keep their last value.
      r_state   <= EMPTY;
      r_tag     <= TAG_ZERO;
      r_credits <= CRED_MAX;
    end else begin
      if (w_pop) begin
        r_state <= FULL;
        r_pc    <= pc_from_instr_queue;
        r_instr <= instr_from_instr_queue;
      end else if (w_can_issue) begin
        r_state <= EMPTY;
      end
      // Tag width equals log2(RobDepth), so the natural overflow is the wrap.
      if (w_can_issue) begin
        r_tag <= r_tag + TAG_ONE;
      end
      r_credits <= next_credits(r_credits, w_can_issue, commit_from_rob);
    end
  end

endmodule
